// File: rtl/cpu_types_pkg.sv
// CPU-wide scalar types shared by the pipeline stages.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Types for the memory stage controller: the access FSM encoding and the alignment helper.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package diaosi_types_pkg;

    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memst_t;

    // Data accesses are word-only; any nonzero byte offset is unaligned.
    function automatic logic word_aligned(input word_t addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
// Latency: count visible one cycle after the inc it reflects.
// Backpressure: none; inc is accepted every cycle, ignored once saturated.
//
// Ports: CLK, nRST (async active-low), inc (count this cycle), cnt (current count).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data access controller: one memory access per EX/MEM instruction, stalling on dwait.
// Latency: request driven combinationally in the issue cycle; dhit same cycle dwait is low; dmemload one edge later.
// Backpressure: dwait high holds the request and raises mem_stall; DONE waits for pipe_adv before re-arming.
//
// Ports:
//   CLK, nRST                      clock, async active-low reset
//   d_ren_o3, d_wen_o3             EX/MEM load / store request
//   dmemaddr_o3, dmemstore_o3      EX/MEM address and store data
//   halt_o3, pipe_adv              EX/MEM halt marker, EX/MEM register advancing this cycle
//   dwait, dload                   memory controller busy and read data
//   dREN, dWEN, daddr, dstore      request to memory controller (combinational)
//   dhit, mem_stall                access completed pulse, pipeline hold (combinational)
//   dmemload                       latched load data
//   halted, misalign               sticky status flags
//   wait_cnt                       saturating count of dwait-stalled cycles
module mem_stage_ctrl
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter int WAITCNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 d_ren_o3,
    input  logic                 d_wen_o3,
    input  logic [31:0]          dmemaddr_o3,
    input  logic [31:0]          dmemstore_o3,
    input  logic                 halt_o3,
    input  logic                 pipe_adv,
    input  logic                 dwait,
    input  logic [31:0]          dload,
    output logic                 dREN,
    output logic                 dWEN,
    output logic [31:0]          daddr,
    output logic [31:0]          dstore,
    output logic                 dhit,
    output logic [31:0]          dmemload,
    output logic                 mem_stall,
    output logic                 halted,
    output logic                 misalign,
    output logic [WAITCNT_W-1:0] wait_cnt
);

    memst_t state;
    logic   req_any;
    logic   aligned;
    logic   pending;
    logic   active;
    word_t  load_q;

    assign req_any = d_ren_o3 | d_wen_o3;
    assign aligned = word_aligned(dmemaddr_o3);
    assign pending = req_any & aligned & ~halted;

    // A request is on the bus when a fresh aligned access arrives in IDLE, or
    // for the whole of BUSY: an in-flight access is never abandoned by flush or
    // pipe_adv. Gating with nRST keeps every combinational output low in reset.
    always_comb begin
        active    = 1'b0;
        dWEN      = 1'b0;
        dREN      = 1'b0;
        daddr     = '0;
        dstore    = '0;
        dhit      = 1'b0;
        mem_stall = 1'b0;
        if (nRST) begin
            active = ((state == IDLE) && pending) || (state == BUSY);
        end
        if (active) begin
            // Store wins when both request lines are set.
            dWEN      = d_wen_o3;
            dREN      = d_ren_o3 & ~d_wen_o3;
            daddr     = dmemaddr_o3;
            dstore    = dmemstore_o3;
            dhit      = ~dwait;
            mem_stall = dwait;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            load_q   <= '0;
            halted   <= 1'b0;
            misalign <= 1'b0;
        end else begin
            if (halt_o3 && pipe_adv) begin
                halted <= 1'b1;
            end
            // Unaligned accesses are dropped silently apart from this flag.
            if ((state == IDLE) && req_any && !aligned && !halted) begin
                misalign <= 1'b1;
            end
            if (dhit && dREN) begin
                load_q <= dload;
            end
            case (state)
                IDLE: begin
                    if (pending) begin
                        if (dwait) begin
                            state <= BUSY;
                        end else if (!pipe_adv) begin
                            // Instruction stays in EX/MEM: park so it is not re-issued.
                            state <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (!dwait) begin
                        state <= pipe_adv ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (pipe_adv) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dmemload = load_q;

    // Every cycle the pipeline is held on dwait counts, including the issue
    // cycle in IDLE that first sees dwait high.
    sat_counter #(
        .W (WAITCNT_W)
    ) u_wait_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (mem_stall),
        .cnt  (wait_cnt)
    );

endmodule
